// File: rtl/mode_counter_pkg.sv
// Shared types for the mode counter: direction-mode encoding used by the RTL and benches.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } cnt_mode_t;

endpackage

// File: rtl/mode_counter_if.sv
// Control/status bundle of one counter channel; the counter is the slave side.
interface mode_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             en;
    cnt_mode_t        mode;
    logic             wrap;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             tick;
    logic             tc;

    modport master (
        output en, mode, wrap, load, load_val, limit,
        input  count, dir, tick, tc
    );

    modport slave (
        input  en, mode, wrap, load, load_val, limit,
        output count, dir, tick, tc
    );
endinterface

// File: rtl/mode_counter_prescaler.sv
// Clock-enable prescaler: asserts step once every PRESCALE enabled cycles.
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic step
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_reg;
    logic [PW-1:0] phase_next;

    // clr (load) suppresses the step even when the phase is due
    assign step = en && !clr && (phase_reg == LAST);

    always_comb begin
        phase_next = phase_reg;
        if (clr) begin
            phase_next = '0;
        end else if (en) begin
            phase_next = (phase_reg == LAST) ? '0 : phase_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end
endmodule

// File: rtl/mode_counter.sv
// One counter channel: up/down/bounce/hold modes, programmable limit, wrap or saturate,
// synchronous load and prescaled stepping. All outputs registered.
module mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input logic          clk,
    input logic          reset,
    mode_counter_if.slave bus
);
    logic [WIDTH-1:0] count_reg, count_next;
    logic             dir_reg, dir_next;
    logic             tick_reg, tick_next;
    logic             tc_reg, tc_next;
    logic             step;
    logic             run;

    // HOLD freezes the prescaler phase as well as the count
    assign run = bus.en && (bus.mode != MODE_HOLD);

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (run),
        .clr  (bus.load),
        .step (step)
    );

    always_comb begin
        count_next = count_reg;
        dir_next   = dir_reg;
        tick_next  = 1'b0;
        tc_next    = 1'b0;

        case (bus.mode)
            MODE_UP:   dir_next = 1'b1;
            MODE_DOWN: dir_next = 1'b0;
            default:   ;
        endcase

        if (bus.load) begin
            count_next = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
        end else if (step) begin
            tick_next = 1'b1;
            case (bus.mode)
                MODE_UP: begin
                    // a count above a freshly lowered limit counts as at-bound
                    if (count_reg < bus.limit) begin
                        count_next = count_reg + 1'b1;
                    end else begin
                        count_next = bus.wrap ? '0 : bus.limit;
                        tc_next    = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (count_reg != '0) begin
                        count_next = count_reg - 1'b1;
                    end else begin
                        count_next = bus.wrap ? bus.limit : '0;
                        tc_next    = 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    if (bus.limit == '0) begin
                        count_next = '0;
                        tc_next    = 1'b1;
                    end else if (dir_reg) begin
                        if (count_reg < bus.limit) begin
                            count_next = count_reg + 1'b1;
                        end else begin
                            count_next = bus.limit - 1'b1;
                            dir_next   = 1'b0;
                            tc_next    = 1'b1;
                        end
                    end else begin
                        if (count_reg != '0) begin
                            count_next = count_reg - 1'b1;
                        end else begin
                            count_next = {{(WIDTH-1){1'b0}}, 1'b1};
                            dir_next   = 1'b1;
                            tc_next    = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
            dir_reg   <= 1'b1;
            tick_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            dir_reg   <= dir_next;
            tick_reg  <= tick_next;
            tc_reg    <= tc_next;
        end
    end

    assign bus.count = count_reg;
    assign bus.dir   = dir_reg;
    assign bus.tick  = tick_reg;
    assign bus.tc    = tc_reg;
endmodule
